// File: rtl/impulse_count_deserializer.sv
// impulse_count_deserializer
// Receive side of the multi-channel impulse counter readout. This block
// reassembles MSB-first serial frames into a per-channel count bank, tracks
// which channels have been refreshed, and serves the bank on a
// combinational read port.
//
// state | meaning
// IDLE  | waiting for sl_in; the first high cycle loads bit 0 and latches addr_in
// SHIFT | frame in progress; sl_in low ends the frame and commits or rejects it
module impulse_count_deserializer #(
  parameter int WIDTH = 16,
  parameter int NCH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             sl_in,
  input  logic [3:0]       addr_in,
  input  logic             ovf_in,
  input  logic [2:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_ovf,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [3:0]       frame_ch,
  input  logic             clr_fresh,
  output logic             all_fresh
);

  // bitcnt must reach WIDTH+1 so that any overlong frame stays distinguishable
  // from an exact-length one.
  localparam int BW = $clog2(WIDTH + 2);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [BW-1:0] CNT_ONE  = BW'(1);
  localparam logic [BW-1:0] CNT_FULL = BW'(WIDTH);
  localparam logic [BW-1:0] CNT_SAT  = BW'(WIDTH + 1);
  localparam logic [3:0]    NCH_A    = 4'(NCH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_q;
  logic [BW-1:0]    bitcnt;
  logic [3:0]       addr_q;
  logic [WIDTH-1:0] bank [NCH];
  logic [NCH-1:0]   ovf_q;
  logic [NCH-1:0]   fresh;

  logic             commit_ok;
  logic [CW-1:0]    wr_idx;
  logic [CW-1:0]    rd_idx;
  logic             rd_in_range;

  // A frame is accepted only with exactly WIDTH bits and an address in the bank.
  always_comb begin
    commit_ok = (bitcnt == CNT_FULL) && (addr_q < NCH_A);
    wr_idx    = addr_q[CW-1:0];
  end

  // Frame FSM, bank write, fresh tracking and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shift_q     <= '0;
      bitcnt      <= '0;
      addr_q      <= '0;
      ovf_q       <= '0;
      fresh       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_ch    <= '0;
      for (int i = 0; i < NCH; i++) begin
        bank[i] <= '0;
      end
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;

      // Placed ahead of the commit so a same-cycle commit re-sets its own bit.
      if (clr_fresh) begin
        fresh <= '0;
      end

      case (state)
        IDLE: begin
          if (sl_in) begin
            shift_q <= {{(WIDTH-1){1'b0}}, serial_in};
            bitcnt  <= CNT_ONE;
            addr_q  <= addr_in;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (sl_in) begin
            shift_q <= {shift_q[WIDTH-2:0], serial_in};
            if (bitcnt != CNT_SAT) begin
              bitcnt <= bitcnt + CNT_ONE;
            end
          end else begin
            state    <= IDLE;
            frame_ch <= addr_q;
            if (commit_ok) begin
              bank[wr_idx]  <= shift_q;
              ovf_q[wr_idx] <= ovf_in;
              fresh[wr_idx] <= 1'b1;
              frame_valid   <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Random-access read of the bank; out-of-range addresses read as zero.
  always_comb begin
    rd_in_range = ({1'b0, rd_addr} < NCH_A);
    rd_idx      = rd_addr[CW-1:0];
    rd_data     = '0;
    rd_ovf      = 1'b0;
    if (rd_in_range) begin
      rd_data = bank[rd_idx];
      rd_ovf  = ovf_q[rd_idx];
    end
  end

  // Every channel refreshed since the last clear.
  always_comb begin
    all_fresh = &fresh;
  end

endmodule

// File: tb/tb_impulse_count_deserializer.sv
// Directed testbench for impulse_count_deserializer.
module tb_impulse_count_deserializer;

  localparam int WIDTH = 16;
  localparam int NCH   = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             serial_in;
  logic             sl_in;
  logic [3:0]       addr_in;
  logic             ovf_in;
  logic [2:0]       rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ovf;
  logic             frame_valid;
  logic             frame_err;
  logic [3:0]       frame_ch;
  logic             clr_fresh;
  logic             all_fresh;

  int n_checks = 0;
  int n_fail   = 0;

  impulse_count_deserializer #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk         (clk),
    .reset       (reset),
    .serial_in   (serial_in),
    .sl_in       (sl_in),
    .addr_in     (addr_in),
    .ovf_in      (ovf_in),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_ovf      (rd_ovf),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .frame_ch    (frame_ch),
    .clr_fresh   (clr_fresh),
    .all_fresh   (all_fresh)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n frame bits, MSB first; addr_in is only meaningful on the first bit,
  // so it is deliberately corrupted afterwards.
  task automatic send_bits(input logic [3:0] a, input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sl_in     = 1'b1;
      serial_in = v[i];
      addr_in   = (i == n - 1) ? a : ~a;
      ovf_in    = 1'b0;
      tick();
    end
  endtask

  task automatic end_frame(input logic ovf, input logic clr);
    sl_in     = 1'b0;
    serial_in = 1'b0;
    ovf_in    = ovf;
    clr_fresh = clr;
    tick();
    ovf_in    = 1'b0;
    clr_fresh = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid: got %b expected 0", frame_valid); end
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_checks++;
    if (all_fresh !== 1'b0) begin n_fail++; $display("FAIL reset_all_fresh: got %b expected 0", all_fresh); end
    n_checks++;
    if (frame_ch !== 4'd0) begin n_fail++; $display("FAIL reset_frame_ch: got %0d expected 0", frame_ch); end
    for (int c = 0; c < NCH; c++) begin
      rd_addr = 3'(c);
      #1;
      n_checks++;
      if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_data ch%0d: got %h expected 0000", c, rd_data); end
      n_checks++;
      if (rd_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ovf ch%0d: got %b expected 0", c, rd_ovf); end
    end
    tick();
  endtask

  task automatic test_single_frame();
    send_bits(4'd3, 32'h0000_A5C3, 16);
    end_frame(1'b1, 1'b0);
    n_checks++;
    if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", frame_valid); end
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b expected 0", frame_err); end
    n_checks++;
    if (frame_ch !== 4'd3) begin n_fail++; $display("FAIL single_ch: got %0d expected 3", frame_ch); end
    tick();
    n_checks++;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %b expected 0", frame_valid); end
    for (int c = 0; c < NCH; c++) begin
      rd_addr = 3'(c);
      #1;
      n_checks++;
      if (rd_data !== ((c == 3) ? 16'hA5C3 : 16'h0000)) begin
        n_fail++; $display("FAIL single_rd_data ch%0d: got %h expected %h", c, rd_data, (c == 3) ? 16'hA5C3 : 16'h0000);
      end
      n_checks++;
      if (rd_ovf !== (c == 3)) begin n_fail++; $display("FAIL single_rd_ovf ch%0d: got %b expected %b", c, rd_ovf, (c == 3)); end
    end
    tick();
  endtask

  task automatic test_length_errors();
    send_bits(4'd2, 32'h0000_7FFF, 15);
    end_frame(1'b1, 1'b0);
    n_checks++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL short_err: got %b expected 1", frame_err); end
    n_checks++;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL short_valid: got %b expected 0", frame_valid); end
    n_checks++;
    if (frame_ch !== 4'd2) begin n_fail++; $display("FAIL short_ch: got %0d expected 2", frame_ch); end
    tick();
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL short_pulse_width: got %b expected 0", frame_err); end
    rd_addr = 3'd2;
    #1;
    n_checks++;
    if (rd_data !== 16'h0000 || rd_ovf !== 1'b0) begin n_fail++; $display("FAIL short_bank2: got %h/%b expected 0000/0", rd_data, rd_ovf); end

    send_bits(4'd2, 32'h0001_FFFF, 17);
    end_frame(1'b1, 1'b0);
    n_checks++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL long_err: got %b expected 1", frame_err); end
    n_checks++;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL long_valid: got %b expected 0", frame_valid); end
    n_checks++;
    if (frame_ch !== 4'd2) begin n_fail++; $display("FAIL long_ch: got %0d expected 2", frame_ch); end
    rd_addr = 3'd2;
    #1;
    n_checks++;
    if (rd_data !== 16'h0000 || rd_ovf !== 1'b0) begin n_fail++; $display("FAIL long_bank2: got %h/%b expected 0000/0", rd_data, rd_ovf); end
    tick();
  endtask

  task automatic test_bad_address();
    send_bits(4'd9, 32'h0000_FFFF, 16);
    end_frame(1'b1, 1'b0);
    n_checks++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL badaddr_err: got %b expected 1", frame_err); end
    n_checks++;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL badaddr_valid: got %b expected 0", frame_valid); end
    n_checks++;
    if (frame_ch !== 4'd9) begin n_fail++; $display("FAIL badaddr_ch: got %0d expected 9", frame_ch); end
    n_checks++;
    if (all_fresh !== 1'b0) begin n_fail++; $display("FAIL badaddr_all_fresh: got %b expected 0", all_fresh); end
    for (int c = 0; c < NCH; c++) begin
      rd_addr = 3'(c);
      #1;
      n_checks++;
      if (rd_data !== ((c == 3) ? 16'hA5C3 : 16'h0000)) begin
        n_fail++; $display("FAIL badaddr_bank ch%0d: got %h expected %h", c, rd_data, (c == 3) ? 16'hA5C3 : 16'h0000);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    for (int c = 0; c < NCH; c++) begin
      send_bits(4'(c), 32'(c + 1), 16);
      end_frame(1'(c & 1), 1'b0);
      if (frame_valid === 1'b1) pulses++;
      n_checks++;
      if (frame_ch !== 4'(c)) begin n_fail++; $display("FAIL sweep_ch: got %0d expected %0d", frame_ch, c); end
      if (c == NCH - 2) begin
        n_checks++;
        if (all_fresh !== 1'b0) begin n_fail++; $display("FAIL sweep_fresh_early: got %b expected 0", all_fresh); end
      end
    end
    n_checks++;
    if (pulses != NCH) begin n_fail++; $display("FAIL sweep_pulses: got %0d expected %0d", pulses, NCH); end
    n_checks++;
    if (all_fresh !== 1'b1) begin n_fail++; $display("FAIL sweep_fresh_rise: got %b expected 1", all_fresh); end

    // bad address right behind the sweep must not disturb the fresh state
    send_bits(4'd12, 32'h0000_1111, 16);
    end_frame(1'b0, 1'b0);
    n_checks++;
    if (frame_err !== 1'b1 || frame_ch !== 4'd12) begin n_fail++; $display("FAIL sweep_badaddr: got err=%b ch=%0d expected err=1 ch=12", frame_err, frame_ch); end
    n_checks++;
    if (all_fresh !== 1'b1) begin n_fail++; $display("FAIL sweep_badaddr_fresh: got %b expected 1", all_fresh); end

    for (int c = 0; c < NCH; c++) begin
      rd_addr = 3'(c);
      #1;
      n_checks++;
      if (rd_data !== 16'(c + 1) || rd_ovf !== 1'(c & 1)) begin
        n_fail++; $display("FAIL sweep_rd ch%0d: got %h/%b expected %h/%b", c, rd_data, rd_ovf, 16'(c + 1), 1'(c & 1));
      end
    end
    tick();

    // clear coincident with a ch5 commit; old value visible until the commit edge
    send_bits(4'd5, 32'h0000_0055, 16);
    rd_addr = 3'd5;
    #1;
    n_checks++;
    if (rd_data !== 16'h0006) begin n_fail++; $display("FAIL commit_old_value: got %h expected 0006", rd_data); end
    end_frame(1'b1, 1'b1);
    n_checks++;
    if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL clr_commit_valid: got %b expected 1", frame_valid); end
    n_checks++;
    if (all_fresh !== 1'b0) begin n_fail++; $display("FAIL clr_commit_fresh: got %b expected 0", all_fresh); end
    n_checks++;
    if (rd_data !== 16'h0055 || rd_ovf !== 1'b1) begin n_fail++; $display("FAIL commit_new_value: got %h/%b expected 0055/1", rd_data, rd_ovf); end

    // refreshing every channel except 5 must complete all_fresh if fresh[5] survived
    for (int c = 0; c < NCH; c++) begin
      if (c != 5) begin
        send_bits(4'(c), 32'(16'h0100 + c), 16);
        end_frame(1'b0, 1'b0);
        if (c == 6) begin
          n_checks++;
          if (all_fresh !== 1'b0) begin n_fail++; $display("FAIL fresh5_early: got %b expected 0", all_fresh); end
        end
      end
    end
    n_checks++;
    if (all_fresh !== 1'b1) begin n_fail++; $display("FAIL fresh5_kept: got %b expected 1", all_fresh); end

    clr_fresh = 1'b1;
    tick();
    clr_fresh = 1'b0;
    n_checks++;
    if (all_fresh !== 1'b0) begin n_fail++; $display("FAIL clr_alone: got %b expected 0", all_fresh); end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    send_bits(4'd1, 32'h0000_00BE, 8);
    reset = 1'b1;
    sl_in = 1'b1;
    tick();
    reset = 1'b0;
    sl_in = 1'b0;
    n_checks++;
    if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL abort_pulse_reset: got v=%b e=%b expected 0/0", frame_valid, frame_err); end
    tick();
    n_checks++;
    if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL abort_pulse_after: got v=%b e=%b expected 0/0", frame_valid, frame_err); end
    rd_addr = 3'd3;
    #1;
    n_checks++;
    if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL abort_bank_cleared: got %h expected 0000", rd_data); end
    tick();

    send_bits(4'd1, 32'h0000_1234, 16);
    end_frame(1'b0, 1'b0);
    n_checks++;
    if (frame_valid !== 1'b1 || frame_ch !== 4'd1) begin n_fail++; $display("FAIL clean_frame: got v=%b ch=%0d expected 1/1", frame_valid, frame_ch); end
    rd_addr = 3'd1;
    #1;
    n_checks++;
    if (rd_data !== 16'h1234) begin n_fail++; $display("FAIL clean_rd_data: got %h expected 1234", rd_data); end
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    serial_in = 1'b0;
    sl_in     = 1'b0;
    addr_in   = 4'd0;
    ovf_in    = 1'b0;
    rd_addr   = 3'd0;
    clr_fresh = 1'b0;

    test_reset();
    test_single_frame();
    test_length_errors();
    test_bad_address();
    test_back_to_back();
    test_reset_mid_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
